// File: rtl/reaction_timing_stage_if.sv
// Bundle of the sequencer-facing signals of the reaction timing stage.
//   enable     : stage select from the top-level sequencer
//   KEY        : raw active-low pushbuttons (KEY[0] = reaction button)
//   ledr       : LED bar
//   hex0..hex2 : active-low 7-segment digits, hex0 = ones
//   score_a..c : latched BCD result, a = ones, c = hundreds
//   out_state  : next-state request to the sequencer (2 = stay, 3 = done)
interface reaction_timing_stage_if;
    logic       enable;
    logic [1:0] KEY;
    logic [9:0] ledr;
    logic [7:0] hex0;
    logic [7:0] hex1;
    logic [7:0] hex2;
    logic [3:0] score_a;
    logic [3:0] score_b;
    logic [3:0] score_c;
    logic [3:0] out_state;

    // Sequencer / board side.
    modport master (
        output enable, KEY,
        input  ledr, hex0, hex1, hex2, score_a, score_b, score_c, out_state
    );

    // Timing stage side.
    modport slave (
        input  enable, KEY,
        output ledr, hex0, hex1, hex2, score_a, score_b, score_c, out_state
    );
endinterface

// File: rtl/reaction_timing_stage.sv
// Reaction timing stage: once enabled and the button is released, counts
// milliseconds in 3-digit BCD until KEY[0] is pressed (or 999 ms elapse),
// latches the count as the score and asks the sequencer to advance.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-low
//   bus   : sequencer-facing signals (see reaction_timing_stage_if)
// MS_DIV is the number of clk cycles per 1 ms tick (2 .. 2^20).
module reaction_timing_stage #(
    parameter int unsigned MS_DIV = 50000
) (
    input  logic                         clk,
    input  logic                         reset,
    reaction_timing_stage_if.slave       bus
);

    localparam int unsigned DivW = (MS_DIV > 2) ? $clog2(MS_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(MS_DIV - 1);

    typedef enum logic [1:0] {StIdle, StArm, StCount, StDone} state_e;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [2:0][3:0] cnt_q, cnt_d, cnt_inc;
    logic [2:0][3:0] score_q, score_d;
    logic [3:0]      out_state_q;
    logic            key_meta_q, key_sync_q, key_prev_q;
    logic            press, tick, cnt_max;

    logic unused_key1;
    assign unused_key1 = bus.KEY[1];

    // Falling edge of the synchronized button is a press.
    assign press   = key_prev_q & ~key_sync_q;
    assign tick    = (state_q == StCount) && (div_q == DivMax);
    assign cnt_max = (cnt_q[0] == 4'd9) && (cnt_q[1] == 4'd9) && (cnt_q[2] == 4'd9);

    // BCD increment with digit carry; the 999 case is handled by saturation.
    always_comb begin
        cnt_inc = cnt_q;
        if (cnt_q[0] == 4'd9) begin
            cnt_inc[0] = 4'd0;
            if (cnt_q[1] == 4'd9) begin
                cnt_inc[1] = 4'd0;
                cnt_inc[2] = cnt_q[2] + 4'd1;
            end else begin
                cnt_inc[1] = cnt_q[1] + 4'd1;
            end
        end else begin
            cnt_inc[0] = cnt_q[0] + 4'd1;
        end
    end

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            div_q       <= '0;
            cnt_q       <= '0;
            score_q     <= '0;
            out_state_q <= 4'd2;
            key_meta_q  <= 1'b1;
            key_sync_q  <= 1'b1;
            key_prev_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            score_q     <= score_d;
            out_state_q <= (state_d == StDone) ? 4'd3 : 4'd2;
            key_meta_q  <= bus.KEY[0];
            key_sync_q  <= key_meta_q;
            key_prev_q  <= key_sync_q;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.enable) state_d = StArm;
            // Wait for release so a button held from the previous stage is not a press.
            StArm:   if (key_sync_q) state_d = StCount;
            StCount: if (press || (tick && cnt_max)) state_d = StDone;
            StDone:  state_d = StDone;
            default: state_d = StIdle;
        endcase
        if (!bus.enable) state_d = StIdle;
    end

    // Divider, counter and score next-state.
    always_comb begin
        div_d   = div_q;
        cnt_d   = cnt_q;
        score_d = score_q;
        unique case (state_q)
            StIdle: begin
                div_d = '0;
                cnt_d = '0;
            end
            StArm: begin
                if (key_sync_q) begin
                    div_d = '0;
                    cnt_d = '0;
                end
            end
            StCount: begin
                if (press) begin
                    // A tick coinciding with the press is discarded.
                    score_d = cnt_q;
                end else begin
                    div_d = tick ? '0 : div_q + 1'b1;
                    if (tick) begin
                        if (cnt_max) score_d = cnt_q;
                        else         cnt_d   = cnt_inc;
                    end
                end
            end
            default: ;
        endcase
        if (!bus.enable) begin
            div_d   = '0;
            cnt_d   = '0;
            score_d = score_q;
        end
    end

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // Output logic.
    always_comb begin
        bus.hex0 = 8'hFF;
        bus.hex1 = 8'hFF;
        bus.hex2 = 8'hFF;
        bus.ledr = '0;
        unique case (state_q)
            StIdle: ;
            StArm: begin
                bus.hex0 = seg7(cnt_q[0]);
                bus.hex1 = seg7(cnt_q[1]);
                bus.hex2 = seg7(cnt_q[2]);
            end
            StCount: begin
                bus.hex0 = seg7(cnt_q[0]);
                bus.hex1 = seg7(cnt_q[1]);
                bus.hex2 = seg7(cnt_q[2]);
                // Thermometer of the hundreds digit: ledr[n:0] lit.
                bus.ledr = 10'h3FF >> (4'd9 - cnt_q[2]);
            end
            StDone: begin
                bus.hex0 = seg7(score_q[0]);
                bus.hex1 = seg7(score_q[1]);
                bus.hex2 = seg7(score_q[2]);
                bus.ledr = ((score_q[0] == 4'd9) && (score_q[1] == 4'd9) &&
                            (score_q[2] == 4'd9)) ? 10'h3FF : 10'h001;
            end
            default: ;
        endcase
    end

    assign bus.score_a   = score_q[0];
    assign bus.score_b   = score_q[1];
    assign bus.score_c   = score_q[2];
    assign bus.out_state = out_state_q;

endmodule

// File: tb/tb_reaction_timing_stage.sv
module tb_reaction_timing_stage;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    reaction_timing_stage_if bus ();

    reaction_timing_stage #(.MS_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges; inputs change and outputs are sampled 1 time unit later.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.enable = 1'b0;
        bus.KEY = 2'b11;
        cyc(2);
        n_vec++;
        if (bus.hex0 !== 8'hFF || bus.hex1 !== 8'hFF || bus.hex2 !== 8'hFF) begin
            $display("FAIL reset_hex got %h %h %h want FF FF FF", bus.hex2, bus.hex1, bus.hex0);
            n_err++;
        end
        n_vec++;
        if (bus.ledr !== 10'h000 || bus.out_state !== 4'd2) begin
            $display("FAIL reset_led_state got ledr=%h os=%0d want 000/2", bus.ledr, bus.out_state);
            n_err++;
        end
        n_vec++;
        if ({bus.score_c, bus.score_b, bus.score_a} !== 12'h000) begin
            $display("FAIL reset_score got %h want 000", {bus.score_c, bus.score_b, bus.score_a});
            n_err++;
        end
        reset = 1'b1;
        cyc(1);
    endtask

    task automatic test_press();
        bus.enable = 1'b1;
        cyc(2);                     // IDLE -> ARM -> COUNT at 000
        n_vec++;
        if (bus.hex0 !== 8'hC0 || bus.ledr !== 10'h001) begin
            $display("FAIL count_start got hex0=%h ledr=%h want C0/001", bus.hex0, bus.ledr);
            n_err++;
        end
        cyc(4 * 37);
        n_vec++;
        if ({bus.hex2, bus.hex1, bus.hex0} !== 24'hC0B0F8) begin
            $display("FAIL live_037 got %h want C0B0F8", {bus.hex2, bus.hex1, bus.hex0});
            n_err++;
        end
        bus.KEY = 2'b10;
        cyc(2);                     // press still travelling through the synchronizer
        n_vec++;
        if (bus.out_state !== 4'd2 || bus.score_b !== 4'd0) begin
            $display("FAIL pre_latch got os=%0d b=%0d want 2/0", bus.out_state, bus.score_b);
            n_err++;
        end
        cyc(1);
        n_vec++;
        if ({bus.score_c, bus.score_b, bus.score_a} !== 12'h037 || bus.out_state !== 4'd3) begin
            $display("FAIL press_037 got score=%h os=%0d want 037/3",
                     {bus.score_c, bus.score_b, bus.score_a}, bus.out_state);
            n_err++;
        end
        n_vec++;
        if ({bus.hex2, bus.hex1, bus.hex0} !== 24'hC0B0F8 || bus.ledr !== 10'h001) begin
            $display("FAIL done_disp got hex=%h ledr=%h want C0B0F8/001",
                     {bus.hex2, bus.hex1, bus.hex0}, bus.ledr);
            n_err++;
        end
        // A second press while DONE must not change anything.
        bus.KEY = 2'b11;
        cyc(5);
        bus.KEY = 2'b10;
        cyc(5);
        n_vec++;
        if ({bus.score_c, bus.score_b, bus.score_a} !== 12'h037 || bus.out_state !== 4'd3) begin
            $display("FAIL done_press got score=%h os=%0d want 037/3",
                     {bus.score_c, bus.score_b, bus.score_a}, bus.out_state);
            n_err++;
        end
        bus.enable = 1'b0;
        cyc(1);
        n_vec++;
        if (bus.hex0 !== 8'hFF || bus.out_state !== 4'd2 || bus.score_a !== 4'd7) begin
            $display("FAIL done_exit got hex0=%h os=%0d a=%0d want FF/2/7",
                     bus.hex0, bus.out_state, bus.score_a);
            n_err++;
        end
    endtask

    // Held button, then carries, then enable drop at 512; ends in IDLE.
    task automatic test_held_carry_drop();
        bus.KEY = 2'b10;
        cyc(3);
        bus.enable = 1'b1;
        cyc(1 + 20);
        n_vec++;
        if (bus.ledr !== 10'h000 || {bus.hex2, bus.hex1, bus.hex0} !== 24'hC0C0C0) begin
            $display("FAIL held_arm got ledr=%h hex=%h want 000/C0C0C0",
                     bus.ledr, {bus.hex2, bus.hex1, bus.hex0});
            n_err++;
        end
        bus.KEY = 2'b11;
        cyc(2);
        n_vec++;
        if (bus.ledr !== 10'h000 || bus.score_b !== 4'd3 || bus.out_state !== 4'd2) begin
            $display("FAIL held_release got ledr=%h b=%0d os=%0d want 000/3/2",
                     bus.ledr, bus.score_b, bus.out_state);
            n_err++;
        end
        cyc(1);                     // now COUNT at 000
        cyc(4 * 99);
        n_vec++;
        if ({bus.hex2, bus.hex1, bus.hex0} !== 24'hC09090 || bus.ledr !== 10'h001) begin
            $display("FAIL cnt_099 got hex=%h ledr=%h want C09090/001",
                     {bus.hex2, bus.hex1, bus.hex0}, bus.ledr);
            n_err++;
        end
        cyc(4);
        n_vec++;
        if ({bus.hex2, bus.hex1, bus.hex0} !== 24'hF9C0C0 || bus.ledr !== 10'h003) begin
            $display("FAIL carry_100 got hex=%h ledr=%h want F9C0C0/003",
                     {bus.hex2, bus.hex1, bus.hex0}, bus.ledr);
            n_err++;
        end
        cyc(4 * 10);
        n_vec++;
        if ({bus.hex2, bus.hex1, bus.hex0} !== 24'hF9F9C0) begin
            $display("FAIL carry_110 got %h want F9F9C0", {bus.hex2, bus.hex1, bus.hex0});
            n_err++;
        end
        cyc(4 * (512 - 110));
        n_vec++;
        if ({bus.hex2, bus.hex1, bus.hex0} !== 24'h92F9A4 || bus.ledr !== 10'h03F) begin
            $display("FAIL cnt_512 got hex=%h ledr=%h want 92F9A4/03F",
                     {bus.hex2, bus.hex1, bus.hex0}, bus.ledr);
            n_err++;
        end
        bus.enable = 1'b0;
        cyc(1);
        n_vec++;
        if ({bus.hex2, bus.hex1, bus.hex0} !== 24'hFFFFFF || bus.out_state !== 4'd2 ||
            {bus.score_c, bus.score_b, bus.score_a} !== 12'h037 || bus.ledr !== 10'h000) begin
            $display("FAIL enable_drop got hex=%h os=%0d score=%h ledr=%h want FFFFFF/2/037/000",
                     {bus.hex2, bus.hex1, bus.hex0}, bus.out_state,
                     {bus.score_c, bus.score_b, bus.score_a}, bus.ledr);
            n_err++;
        end
    endtask

    task automatic test_timeout();
        bus.enable = 1'b1;
        cyc(2);
        cyc(4 * 999 + 3);
        n_vec++;
        if ({bus.hex2, bus.hex1, bus.hex0} !== 24'h909090 || bus.ledr !== 10'h3FF ||
            bus.out_state !== 4'd2) begin
            $display("FAIL cnt_999 got hex=%h ledr=%h os=%0d want 909090/3FF/2",
                     {bus.hex2, bus.hex1, bus.hex0}, bus.ledr, bus.out_state);
            n_err++;
        end
        cyc(1);
        n_vec++;
        if ({bus.score_c, bus.score_b, bus.score_a} !== 12'h999 || bus.out_state !== 4'd3 ||
            bus.ledr !== 10'h3FF) begin
            $display("FAIL timeout got score=%h os=%0d ledr=%h want 999/3/3FF",
                     {bus.score_c, bus.score_b, bus.score_a}, bus.out_state, bus.ledr);
            n_err++;
        end
        cyc(40);
        n_vec++;
        if ({bus.score_c, bus.score_b, bus.score_a} !== 12'h999 || bus.out_state !== 4'd3) begin
            $display("FAIL timeout_hold got score=%h os=%0d want 999/3",
                     {bus.score_c, bus.score_b, bus.score_a}, bus.out_state);
            n_err++;
        end
        bus.enable = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset_in_done();
        bus.enable = 1'b1;
        cyc(2);
        cyc(4 * 245);
        bus.KEY = 2'b10;
        cyc(3);
        n_vec++;
        if ({bus.score_c, bus.score_b, bus.score_a} !== 12'h245 ||
            {bus.hex2, bus.hex1, bus.hex0} !== 24'hA49992) begin
            $display("FAIL press_245 got score=%h hex=%h want 245/A49992",
                     {bus.score_c, bus.score_b, bus.score_a}, {bus.hex2, bus.hex1, bus.hex0});
            n_err++;
        end
        reset = 1'b0;               // enable stays high and button held: reset still wins
        cyc(1);
        n_vec++;
        if ({bus.score_c, bus.score_b, bus.score_a} !== 12'h000 || bus.out_state !== 4'd2 ||
            bus.ledr !== 10'h000 || {bus.hex2, bus.hex1, bus.hex0} !== 24'hFFFFFF) begin
            $display("FAIL reset_done got score=%h os=%0d ledr=%h hex=%h want 000/2/000/FFFFFF",
                     {bus.score_c, bus.score_b, bus.score_a}, bus.out_state, bus.ledr,
                     {bus.hex2, bus.hex1, bus.hex0});
            n_err++;
        end
        reset = 1'b1;
        bus.KEY = 2'b11;
        cyc(2);
        n_vec++;
        if ({bus.hex2, bus.hex1, bus.hex0} !== 24'hC0C0C0 || bus.ledr !== 10'h001) begin
            $display("FAIL fresh_run got hex=%h ledr=%h want C0C0C0/001",
                     {bus.hex2, bus.hex1, bus.hex0}, bus.ledr);
            n_err++;
        end
        cyc(4 * 3);
        n_vec++;
        if (bus.hex0 !== 8'hB0 || bus.hex1 !== 8'hC0) begin
            $display("FAIL fresh_003 got hex1=%h hex0=%h want C0/B0", bus.hex1, bus.hex0);
            n_err++;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        bus.enable = 1'b0;
        bus.KEY = 2'b11;
        test_reset();
        test_press();
        test_held_carry_drop();
        test_timeout();
        test_reset_in_done();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reaction_timing_stage.md
REACTION_TIMING_STAGE -- requirements
Module: reaction_timing_stage

Interface
REQ-001 Parameter MS_DIV, default 50000; clk cycles per 1 ms tick, valid range 2 to 2^20.
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 reset  input  1  one clock; reset is synchronous and active-low.
REQ-004 enable  input  1  stage select from the top-level sequencer; high while the top-level is in the timing state.
REQ-005 KEY  input  2  raw pushbuttons, active-low; KEY[0] is the reaction button, KEY[1] is unused.
REQ-006 ledr  output  10  LED bar.
REQ-007 hex0, hex1, hex2  output  8 each  active-low 7-seg digits; bit 7 is the decimal point, always 1; hex0 is ones, hex2 is hundreds.
REQ-008 score_a, score_b, score_c  output  4 each  latched BCD result; a is ones, b is tens, c is hundreds.
REQ-009 out_state  output  4  next-state request to the sequencer: 2 means stay, 3 means done.

Function
REQ-010 KEY[0] SHALL pass through a 2-flop synchronizer; a press is a 1-to-0 transition of the synchronized signal, detected one cycle after the second flop.
REQ-011 FSM states SHALL be IDLE, ARM, COUNT and DONE.
REQ-012 IDLE: enable=1 -> ARM; otherwise stay.
REQ-013 ARM: synchronized KEY[0]=1 (button released) -> COUNT, with the divider and BCD counter cleared to 000; a button held from the previous stage SHALL NOT count as a press.
REQ-014 COUNT: a 1 ms tick SHALL fire when the divider reaches MS_DIV-1; the divider then wraps to 0; each tick increments a 3-digit BCD counter, with 9 carrying to the next digit.
REQ-015 COUNT, press detected: the current counter value SHALL load score_c/b/a in that cycle -> DONE; a tick in the same cycle is discarded.
REQ-016 COUNT, counter = 999 with a tick and no press: the counter saturates; score = 999 -> DONE (timeout).
REQ-017 DONE: stay until enable=0.
REQ-018 Any state with enable=0 -> IDLE next cycle; counter and divider cleared; scores retained.
REQ-019 out_state SHALL be registered: 3 in DONE, 2 in every other state; it reads 3 on the cycle after the score-latch cycle.
REQ-020 Score outputs SHALL change only on the latch event in REQ-015/016 and on reset.
REQ-021 hex0..hex2: IDLE shows 8'hFF; ARM and COUNT show the live counter; DONE shows the latched score.
REQ-022 Digit codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90; any other nibble shows FF.
REQ-023 ledr: IDLE and ARM show 0.
REQ-024 ledr in COUNT: thermometer of the hundreds digit n, i.e. ledr[n:0] lit.
REQ-025 ledr in DONE: 10'h3FF if score = 999, else 10'h001.
REQ-026 A press in ARM or DONE SHALL be ignored.

Reset
REQ-027 reset=0 at a clock edge SHALL force the following: state IDLE, divider 0, counter 000, scores 0/0/0, out_state 2, ledr 0, hex0..hex2 FF, synchronizer flops 1.
REQ-028 Reset SHALL take priority over enable and over a press in the same cycle.
REQ-029 Reset mid-COUNT SHALL discard the count without latching a score.

Verification (MS_DIV=4)
REQ-030 Normal press: enable=1, KEY[0]=1, press after 37 ticks -> score c/b/a = 0/3/7, hex2/1/0 = C0/B0/F8, out_state=3 on the cycle after the latch.
REQ-031 Held button: KEY[0]=0 at enable rise, released 20 cycles later -> FSM held in ARM for those 20 cycles, counter stays 000, no latch.
REQ-032 Timeout: no press for 1000+ ticks -> score 9/9/9, ledr=3FF, out_state=3.
REQ-033 Enable drop: enable=0 in COUNT at count 512 -> IDLE next cycle, hex FF, scores keep the prior value, out_state=2.
REQ-034 Carry: count 099 plus one tick -> 100 and ledr=10'h003.
REQ-035 Carry: count 109 plus one tick -> 110.
REQ-036 Reset: reset=0 during DONE with score 245 -> all outputs at their REQ-027 values; the next enable gives a fresh run from 000.
